// File: rtl/sigmoid_share_arb.sv
// sigmoid_share_arb: round-robin share of one combinational Q4.12 sigmoid unit between N_REQ requesters
module sigmoid_share_arb #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 16,
  parameter int EVAL_CYCLES = 1,
  parameter int ID_W        = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       sig_x,
  input  logic [DATA_W-1:0]       sig_y,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  input  logic                    rsp_ready,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d, id_q, id_d, gnt_id, idx;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d;
  logic              found;
  // first valid requester strictly after the last grant, wrapping
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ID_W'((int'(last_q) + i) % N_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    req_ready = '0;
    case (state_q)
      IDLE: if (found) begin
        req_ready[gnt_id] = 1'b1;
        x_d     = req_data[gnt_id*DATA_W +: DATA_W];
        id_d    = gnt_id;
        last_d  = gnt_id;
        cnt_d   = 4'(EVAL_CYCLES - 1);
        state_d = EVAL;
      end
      EVAL: if (cnt_q == '0) begin
        y_d     = sig_y;
        state_d = RESP;
      end else cnt_d = cnt_q - 4'd1;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      last_q  <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  assign sig_x     = x_q;
  assign rsp_data  = y_q;
  assign rsp_id    = id_q;
  assign rsp_valid = state_q == RESP;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_sigmoid_share_arb.sv
// tb_sigmoid_share_arb: directed checks of arbitration, settle window, backpressure and reset abort
module tb_sigmoid_share_arb;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0]  a_valid = '0, a_ready, b_valid = '0, b_ready;
  logic [63:0] a_data = '0, b_data = '0;
  logic [15:0] a_x, a_y, a_rdata, b_x, b_y = '0, b_rdata;
  logic [1:0]  a_id, b_id;
  logic        a_rvalid, a_rready = 1'b1, a_busy, b_rvalid, b_busy, mode = 1'b0;
  int          n_tests = 0, n_fail = 0;
  function automatic logic [15:0] sig_ref(input logic [15:0] x);
    int v;
    v = 2048 + ($signed(x) >>> 2);
    return v < 0 ? 16'h0000 : v > 4096 ? 16'h1000 : 16'(v);
  endfunction
  assign a_y = mode ? sig_ref(a_x) : a_x ^ 16'hA5A5;
  sigmoid_share_arb #(.N_REQ(4), .DATA_W(16), .EVAL_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
    .sig_x(a_x), .sig_y(a_y), .rsp_valid(a_rvalid), .rsp_id(a_id), .rsp_data(a_rdata),
    .rsp_ready(a_rready), .busy(a_busy));
  sigmoid_share_arb #(.N_REQ(4), .DATA_W(16), .EVAL_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
    .sig_x(b_x), .sig_y(b_y), .rsp_valid(b_rvalid), .rsp_id(b_id), .rsp_data(b_rdata),
    .rsp_ready(1'b1), .busy(b_busy));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  task automatic do_reset;
    step; rst = 1'b1; step; rst = 1'b0;
  endtask
  initial begin
    a_data[2*16 +: 16] = 16'h1234;
    step; step; rst = 1'b0; #1;
    chk("rst_ready", 32'(a_ready), 32'h0);
    chk("rst_rvalid", 32'(a_rvalid), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_sigx", 32'(a_x), 32'h0);
    chk("rst_rdata", 32'(a_rdata), 32'h0);
    chk("rst_rid", 32'(a_id), 32'h0);
    // single requester 2
    step; a_valid = 4'b0100; #1;
    chk("t1_ready", 32'(a_ready), 32'h4);
    step; a_valid = '0; #1;
    chk("t1_sigx", 32'(a_x), 32'h1234);
    chk("t1_busy", 32'(a_busy), 32'h1);
    chk("t1_rvalid0", 32'(a_rvalid), 32'h0);
    step; #1;
    chk("t1_rvalid", 32'(a_rvalid), 32'h1);
    chk("t1_rid", 32'(a_id), 32'h2);
    chk("t1_rdata", 32'(a_rdata), 32'hB791);
    step; #1;
    chk("t1_idle", 32'(a_rvalid), 32'h0);
    // all four valid: rotation 0,1,2,3,0 with period 3
    do_reset;
    for (int k = 0; k < 4; k++) a_data[k*16 +: 16] = 16'(k + 1);
    a_valid = 4'b1111; #1;
    for (int k = 0; k < 5; k++) begin
      chk("t2_grant", 32'(a_ready), 32'(1 << (k % 4)));
      step; #1;
      chk("t2_eval_ready", 32'(a_ready), 32'h0);
      step; #1;
      chk("t2_rvalid", 32'(a_rvalid), 32'h1);
      chk("t2_rid", 32'(a_id), 32'(k % 4));
      chk("t2_rdata", 32'(a_rdata), 32'((k % 4 + 1) ^ 16'hA5A5));
      step; #1;
    end
    // backpressure: grant to 1 while all valid
    a_rready = 1'b0;
    chk("t3_grant", 32'(a_ready), 32'h2);
    step; step; #1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 32'(a_rvalid), 32'h1);
      chk("t3_hold_id", 32'(a_id), 32'h1);
      chk("t3_hold_data", 32'(a_rdata), 32'hA5A7);
      chk("t3_hold_ready", 32'(a_ready), 32'h0);
      step; #1;
    end
    a_rready = 1'b1; #1;
    chk("t3_release", 32'(a_rvalid), 32'h1);
    step; #1;
    chk("t3_resume", 32'(a_ready), 32'h4);
    step; a_valid = '0; step; step; #1;
    chk("t3_drained", 32'(a_busy), 32'h0);
    // reset during EVAL aborts and reinitialises the pointer
    a_valid = 4'b0010; #1;
    chk("t5_grant", 32'(a_ready), 32'h2);
    step; a_valid = '0; #1;
    chk("t5_in_eval", 32'(a_busy), 32'h1);
    rst = 1'b1; #1;
    chk("t5_rvalid", 32'(a_rvalid), 32'h0);
    chk("t5_busy", 32'(a_busy), 32'h0);
    chk("t5_sigx", 32'(a_x), 32'h0);
    chk("t5_rdata", 32'(a_rdata), 32'h0);
    chk("t5_rid", 32'(a_id), 32'h0);
    step; rst = 1'b0; #1;
    chk("t5_no_rsp", 32'(a_rvalid), 32'h0);
    a_valid = 4'b1010; #1;
    chk("t5_regrant", 32'(a_ready), 32'h2);
    step; a_valid = '0; step; step; #1;
    // EVAL_CYCLES=4: only the value present at the fourth edge is captured
    b_data[0 +: 16] = 16'h0ACE;
    b_valid = 4'b0001; #1;
    chk("t4_grant", 32'(b_ready), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      step;
      if (k == 1) b_valid = '0;
      b_y = 16'(k * 16'h1111); #1;
      chk("t4_sigx", 32'(b_x), 32'h0ACE);
      chk("t4_wait", 32'(b_rvalid), 32'h0);
    end
    step; b_y = 16'h5555; #1;
    chk("t4_rvalid", 32'(b_rvalid), 32'h1);
    chk("t4_rdata", 32'(b_rdata), 32'h4444);
    chk("t4_rid", 32'(b_id), 32'h0);
    step;
    // reference sigmoid behind the arbiter
    mode = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a_data[0 +: 16] = k == 0 ? 16'h0000 : 16'h4000;
      a_valid = 4'b0001;
      step; a_valid = '0; step; #1;
      if (k == 0) chk("t6_half", 32'(a_rdata), 32'h0800);
      else chk("t6_sat", 32'(a_rdata >= 16'h0F80), 32'h1);
      step;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sigmoid_share_arb.md
Name: sigmoid_share_arb

Overview:
- Shares one combinational Q4.12 sigmoid unit between N_REQ requesters using round-robin arbitration.
- Accepts one operand per grant, drives it onto the sigmoid input and holds it for a settle window.
- Captures the sigmoid output and returns it on a single response channel tagged with the requester index.
- Sits between the neuron-lane front ends and the single shared sigmoid instance.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_W, 16, operand/result width (Q4.12)
- EVAL_CYCLES, 1, clock edges sig_x is held before sig_y is captured (1..15)
- ID_W, $clog2(N_REQ), width of requester tag

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  N_REQ  per-requester operand valid
- req_data  in  N_REQ*DATA_W  packed operands, requester k at [k*DATA_W +: DATA_W]
- req_ready  out  N_REQ  one-hot accept strobe
- sig_x  out  DATA_W  operand to shared sigmoid unit
- sig_y  in  DATA_W  result from shared sigmoid unit
- rsp_valid  out  1  response valid
- rsp_id  out  ID_W  requester index of response
- rsp_data  out  DATA_W  captured sigmoid result
- rsp_ready  in  1  downstream accepts response
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; sig_x, rsp_data, rsp_id = 0; rsp_valid=0; req_ready=0; busy=0.
  - Eval counter=0; last-grant pointer=N_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - If any req_valid, grant g = first set bit scanning from (last+1) mod N_REQ upward, with wrap.
  - req_ready[g]=1 combinationally in the same cycle; all other ready bits 0.
  - At the edge: x_reg <= req_data[g]; id_reg <= g; last <= g; counter <= EVAL_CYCLES-1; go to EVAL.
  - If no req_valid: stay in IDLE; req_ready=0.
- EVAL:
  - sig_x = x_reg (registered; stable for the whole window); req_ready=0.
  - When counter==0: rsp_data <= sig_y; go to RESP. Otherwise decrement the counter.
- RESP:
  - rsp_valid=1, rsp_id=id_reg, rsp_data held stable until rsp_ready.
  - On rsp_valid&rsp_ready: go to IDLE; rsp_valid drops the next cycle.
  - A new grant is possible no earlier than the cycle after return to IDLE.
- Timing:
  - Handshake cycle = cycle 0; rsp_valid first high in cycle EVAL_CYCLES+1.
  - With rsp_ready held high, minimum period is EVAL_CYCLES+2 cycles per operation.
- sig_x keeps its last value outside EVAL; it never glitches to requester data in IDLE.
- req_ready is 0 in EVAL/RESP regardless of req_valid, so there is no back-to-back accept.
- A requester dropping req_valid before being granted loses nothing; only a valid&ready handshake transfers data.
- Starvation freedom: with all requesters permanently valid, grants rotate 0,1,…,N_REQ-1,0,…
- Pointer advances only on grant, never on idle cycles.
- Reset asserted mid-EVAL or mid-RESP aborts the operation: no response is produced and the pointer reinitialises.
- req_data is passed bit-exact (no sign manipulation); sig_y is captured bit-exact.
- Out-of-range bits of req_valid do not exist (width exactly N_REQ).

Test Plan:
- Bench stub sig_y = sig_x ^ 16'hA5A5; N_REQ=4, EVAL_CYCLES=1, rsp_ready=1.
  - Single requester 2 sends 0x1234 -> req_ready=4'b0100 in cycle 0, sig_x=0x1234 in cycle 1, rsp_valid in cycle 2 with rsp_id=2, rsp_data=0xB791.
- All four valid continuously with data 0x0001..0x0004 -> grant order 0,1,2,3,0; rsp_valid every 3 cycles; rsp_data = data^0xA5A5 matched to id.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id, rsp_data stable; req_ready stays 0 while requesters are valid; grant resumes one cycle after rsp_ready=1.
- EVAL_CYCLES=4 -> sig_x held 4 cycles; sig_y changed by the stub in the first 3 EVAL cycles is ignored; the value at the 4th edge is captured; rsp_valid in cycle 5.
- Reset pulse during EVAL after grant to requester 1 -> no rsp_valid, all outputs 0, next grant with requests {1,3} goes to requester 1.
- Integration with the real sigmoid unit: request x=0x0000 -> rsp_data=0x0800 (0.5); x=0x4000 (4.0) -> rsp_data ≥ 0x0F80.
